grf_write_queue: RTL and testbench
==================================

GRF_WRITE_QUEUE -- requirements
Module: grf_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered writeback entries; it is a power of 2 and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1 bit: a writeback request is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the queue accepts a request this cycle.
REQ-006 SHALL have port in_a3, input, 5 bits: destination register number.
REQ-007 SHALL have port in_wd, input, 32 bits: write data.
REQ-008 SHALL have port in_pc, input, 32 bits: PC of the producing instruction.
REQ-009 SHALL have port wb_en, input, 1 bit: the register-file write port is available this cycle.
REQ-010 SHALL have port regWrite, output, 1 bit: register-file write enable.
REQ-011 SHALL have port A3, output, 5 bits: register-file write address.
REQ-012 SHALL have port WD, output, 32 bits: register-file write data.
REQ-013 SHALL have port wpc, output, 32 bits: PC tag of the write.
REQ-014 SHALL have ports ra1 and ra2, input, 5 bits each: read addresses to check against pending writes.
REQ-015 SHALL have ports hit1 and hit2, output, 1 bit each: a pending write targets ra1 / ra2.
REQ-016 SHALL have ports fwd1 and fwd2, output, 32 bits each: data of that pending write.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of valid entries.

Function
REQ-018 SHALL hold pending writes in a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter in 0..DEPTH.
REQ-019 SHALL set in_ready = (count < DEPTH) || pop, where pop = regWrite.
REQ-020 SHALL accept a request when in_valid && in_ready; if in_a3 != 0, it SHALL write {in_a3, in_wd, in_pc} at the tail and advance the tail by one.
REQ-021 SHALL treat an accepted request with in_a3 == 0 as consumed, with no enqueue and no count change.
REQ-022 SHALL drive regWrite = (count != 0) && wb_en, combinationally.
REQ-023 SHALL drive A3, WD and wpc from the head entry when count != 0, and drive all three to 0 when count == 0.
REQ-024 SHALL, when regWrite is 1, advance the head by one at the clock edge; at most one write SHALL drain per cycle.
REQ-025 SHALL, on simultaneous enqueue and pop, leave count unchanged; this SHALL also hold at count == DEPTH, where the freed slot is reused that cycle.
REQ-026 SHALL hold the head entry stable on A3/WD/wpc while wb_en is 0, with no loss and no reordering.
REQ-027 SHALL, for hit1/fwd1, search all valid entries, including the head being written this cycle, for A3 == ra1, and select the youngest match (closest to the tail).
REQ-028 SHALL exclude the request arriving this cycle from the hit1/fwd1 search.
REQ-029 SHALL force hit1 = 0 and fwd1 = 0 when ra1 == 0 or there is no match; hit2/fwd2 SHALL use ra2 with identical rules.
REQ-030 SHALL drain writes to the register file in strict acceptance order, so the last write to a register wins.
REQ-031 SHALL never overflow or underflow; count SHALL stay within 0..DEPTH.

Reset
REQ-032 SHALL, on reset high at a clock edge, clear head, tail and count to 0 and discard all entries, including an entry mid-drain or an enqueue in that cycle.
REQ-033 SHALL, in the cycle after reset, output regWrite=0, A3=0, WD=0, wpc=0, hit1=hit2=0, fwd1=fwd2=0, count=0, in_ready=1.

Verification
REQ-034 Bench: wb_en=1; enqueue (a3=5, wd=0x12345678, pc=0x3000) -> next cycle regWrite=1, A3=5, WD=0x12345678, wpc=0x3000; the cycle after, count=0 and regWrite=0.
REQ-035 Bench: wb_en=0; enqueue 4 distinct writes -> count=4, in_ready=0; a 5th request is held; raise wb_en -> in_ready=1 in the same cycle, the 5th is accepted, count stays 4, and the drain order equals the acceptance order.
REQ-036 Bench: wb_en=0; enqueue r7=0x1 then r7=0x2; ra1=7 -> hit1=1, fwd1=0x2; ra2=0 -> hit2=0, fwd2=0.
REQ-037 Bench: enqueue with in_a3=0 -> in_ready=1, count unchanged, no regWrite.
REQ-038 Bench: count=3 with wb_en=1; assert reset in the same cycle as an enqueue -> next cycle count=0, regWrite=0, hit1=0, and no write ever appears for the dropped entries.
REQ-039 Bench: run 200 cycles of random in_valid, wb_en, a3 and wd against a reference model -> the register-write sequence and hit/fwd values match every cycle, and count never exceeds DEPTH.

Source files
------------

// File: rtl/grf_write_queue.sv
// Register-file writeback queue: buffers writebacks in a circular FIFO, drains one per
// cycle when the write port is free, and forwards the youngest pending data to readers.
`timescale 1ns/1ps

module grf_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_a3,
    input  logic [31:0]              in_wd,
    input  logic [31:0]              in_pc,
    input  logic                     wb_en,
    output logic                     regWrite,
    output logic [4:0]               A3,
    output logic [31:0]              WD,
    output logic [31:0]              wpc,
    input  logic [4:0]               ra1,
    input  logic [4:0]               ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              fwd1,
    output logic [31:0]              fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pop;
    logic             accept;
    logic             push;

    assign pop      = (count != '0) && wb_en;
    assign in_ready = (count < FULL) || pop;
    assign accept   = in_valid && in_ready;
    // A write to r0 is architecturally a no-op, so it is consumed without occupying a slot.
    assign push     = accept && (in_a3 != 5'd0);

    assign regWrite = pop;
    assign A3       = (count != '0) ? mem[head].a3 : 5'd0;
    assign WD       = (count != '0) ? mem[head].wd : 32'd0;
    assign wpc      = (count != '0) ? mem[head].pc : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the entry storage is deliberately not reset; validity is defined solely by
    // head/count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{a3: in_a3, wd: in_wd, pc: in_pc};
    end

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit1 = 1'b0;
        fwd1 = 32'd0;
        hit2 = 1'b0;
        fwd2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin : scan
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((ra1 != 5'd0) && (mem[idx].a3 == ra1)) begin
                    hit1 = 1'b1;
                    fwd1 = mem[idx].wd;
                end
                if ((ra2 != 5'd0) && (mem[idx].a3 == ra2)) begin
                    hit2 = 1'b1;
                    fwd2 = mem[idx].wd;
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_write_queue.sv
// Self-checking bench for grf_write_queue: directed vector table, multi-cycle corner
// sequences (full queue, reset mid-drain) and a randomized run against a queue model.
`timescale 1ns/1ps

module tb_grf_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_a3;
    logic [31:0] in_wd;
    logic [31:0] in_pc;
    logic        wb_en;
    logic        regWrite;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] wpc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_fail   = 0;

    grf_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a3(in_a3), .in_wd(in_wd), .in_pc(in_pc), .wb_en(wb_en),
        .regWrite(regWrite), .A3(A3), .WD(WD), .wpc(wpc),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        wb;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        rdy;
        logic        rw;
        logic [4:0]  ea3;
        logic [31:0] ewd;
        logic [31:0] epc;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    vec_t vecs[12];
    ent_t mq[$];

    initial begin
        //           iv a3 wd            pc         wb r1 r2  rdy rw ea3 ewd           epc        h1 f1            h2 f2 cnt
        vecs[0]  = '{0, 0, 0,            0,         1, 0, 0,  1,  0, 0,  0,            0,         0, 0,            0, 0, 0};
        vecs[1]  = '{1, 5, 32'h12345678, 32'h3000,  1, 5, 0,  1,  0, 0,  0,            0,         0, 0,            0, 0, 0};
        vecs[2]  = '{0, 0, 0,            0,         1, 5, 0,  1,  1, 5,  32'h12345678, 32'h3000,  1, 32'h12345678, 0, 0, 1};
        vecs[3]  = '{0, 0, 0,            0,         1, 5, 0,  1,  0, 0,  0,            0,         0, 0,            0, 0, 0};
        vecs[4]  = '{1, 7, 1,            32'h100,   0, 0, 0,  1,  0, 0,  0,            0,         0, 0,            0, 0, 0};
        vecs[5]  = '{1, 7, 2,            32'h104,   0, 7, 0,  1,  0, 7,  1,            32'h100,   1, 1,            0, 0, 1};
        vecs[6]  = '{0, 0, 0,            0,         0, 7, 0,  1,  0, 7,  1,            32'h100,   1, 2,            0, 0, 2};
        vecs[7]  = '{1, 0, 32'hdead,     32'h108,   0, 7, 7,  1,  0, 7,  1,            32'h100,   1, 2,            1, 2, 2};
        vecs[8]  = '{0, 0, 0,            0,         0, 0, 7,  1,  0, 7,  1,            32'h100,   0, 0,            1, 2, 2};
        vecs[9]  = '{0, 0, 0,            0,         1, 7, 0,  1,  1, 7,  1,            32'h100,   1, 2,            0, 0, 2};
        vecs[10] = '{0, 0, 0,            0,         1, 7, 0,  1,  1, 7,  2,            32'h104,   1, 2,            0, 0, 1};
        vecs[11] = '{0, 0, 0,            0,         1, 0, 0,  1,  0, 0,  0,            0,         0, 0,            0, 0, 0};

        reset = 1'b1; in_valid = 1'b0; in_a3 = '0; in_wd = '0; in_pc = '0;
        wb_en = 1'b0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed table: reset state, single write, r7 forwarding, r0 drop, in-order drain.
        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].iv; in_a3 = vecs[i].a3; in_wd = vecs[i].wd; in_pc = vecs[i].pc;
            wb_en = vecs[i].wb; ra1 = vecs[i].r1; ra2 = vecs[i].r2;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].rw));
            check($sformatf("v%0d_A3", i),       32'(A3),       32'(vecs[i].ea3));
            check($sformatf("v%0d_WD", i),       WD,            vecs[i].ewd);
            check($sformatf("v%0d_wpc", i),      wpc,           vecs[i].epc);
            check($sformatf("v%0d_hit1", i),     32'(hit1),     32'(vecs[i].h1));
            check($sformatf("v%0d_fwd1", i),     fwd1,          vecs[i].f1);
            check($sformatf("v%0d_hit2", i),     32'(hit2),     32'(vecs[i].h2));
            check($sformatf("v%0d_fwd2", i),     fwd2,          vecs[i].f2);
            check($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].cnt));
            cyc();
        end

        // Full queue: 5th request held, then accepted in the same cycle the drain starts.
        begin
            int ord_a3[4];
            int ord_wd[4];
            ord_a3 = '{2, 3, 4, 9};
            ord_wd = '{32'h11, 32'h12, 32'h13, 32'h99};
            wb_en = 1'b0; in_valid = 1'b1; ra1 = '0; ra2 = '0;
            for (int k = 0; k < 4; k++) begin
                in_a3 = 5'(k + 1); in_wd = 32'h10 + 32'(k); in_pc = 32'h400 + 32'(4 * k);
                #1 check("fill_in_ready", 32'(in_ready), 1);
                cyc();
            end
            in_a3 = 5'd9; in_wd = 32'h99; in_pc = 32'h500;
            #1;
            check("full_count", 32'(count), 4);
            check("full_in_ready", 32'(in_ready), 0);
            check("full_regWrite", 32'(regWrite), 0);
            cyc();
            #1;
            check("held_count", 32'(count), 4);
            check("held_in_ready", 32'(in_ready), 0);
            check("held_A3", 32'(A3), 1);
            wb_en = 1'b1;
            #1;
            check("release_in_ready", 32'(in_ready), 1);
            check("release_regWrite", 32'(regWrite), 1);
            check("release_A3", 32'(A3), 1);
            check("release_WD", WD, 32'h10);
            cyc();
            in_valid = 1'b0;
            #1 check("swap_count", 32'(count), 4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("order%0d_regWrite", k), 32'(regWrite), 1);
                check($sformatf("order%0d_A3", k), 32'(A3), 32'(ord_a3[k]));
                check($sformatf("order%0d_WD", k), WD, 32'(ord_wd[k]));
                cyc();
            end
            check("drained_count", 32'(count), 0);
            check("drained_regWrite", 32'(regWrite), 0);
        end

        // Reset while three entries are pending, one draining, and an enqueue arriving.
        wb_en = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_a3 = 5'(10 + k); in_wd = 32'hA0 + 32'(k); in_pc = 32'h600 + 32'(4 * k);
            cyc();
        end
        in_a3 = 5'd13; in_wd = 32'hA3; wb_en = 1'b1; reset = 1'b1;
        #1 check("prereset_count", 32'(count), 3);
        cyc();
        reset = 1'b0; in_valid = 1'b0; ra1 = 5'd10; ra2 = 5'd13;
        #1;
        check("postreset_count", 32'(count), 0);
        check("postreset_regWrite", 32'(regWrite), 0);
        check("postreset_hit1", 32'(hit1), 0);
        check("postreset_hit2", 32'(hit2), 0);
        check("postreset_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("noghost%0d_regWrite", k), 32'(regWrite), 0);
        end

        // Randomized run against a queue reference model.
        for (int c = 0; c < 200; c++) begin
            logic        m_pop, m_rdy, m_h1, m_h2;
            logic [4:0]  m_a3;
            logic [31:0] m_wd, m_pc, m_f1, m_f2;
            in_valid = 1'($urandom_range(0, 1));
            wb_en    = 1'($urandom_range(0, 1));
            in_a3    = 5'($urandom_range(0, 7));
            in_wd    = $urandom;
            in_pc    = $urandom;
            ra1      = 5'($urandom_range(0, 7));
            ra2      = 5'($urandom_range(0, 7));
            #1;
            m_pop = (mq.size() != 0) && wb_en;
            m_rdy = (mq.size() < DEPTH) || m_pop;
            m_a3 = '0; m_wd = '0; m_pc = '0;
            if (mq.size() != 0) begin
                m_a3 = mq[0].a3; m_wd = mq[0].wd; m_pc = mq[0].pc;
            end
            m_h1 = 1'b0; m_f1 = '0; m_h2 = 1'b0; m_f2 = '0;
            for (int j = 0; j < mq.size(); j++) begin
                if (ra1 != 0 && mq[j].a3 == ra1) begin m_h1 = 1'b1; m_f1 = mq[j].wd; end
                if (ra2 != 0 && mq[j].a3 == ra2) begin m_h2 = 1'b1; m_f2 = mq[j].wd; end
            end
            check($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(m_rdy));
            check($sformatf("rnd%0d_regWrite", c), 32'(regWrite), 32'(m_pop));
            check($sformatf("rnd%0d_A3", c), 32'(A3), 32'(m_a3));
            check($sformatf("rnd%0d_WD", c), WD, m_wd);
            check($sformatf("rnd%0d_wpc", c), wpc, m_pc);
            check($sformatf("rnd%0d_hit1", c), 32'(hit1), 32'(m_h1));
            check($sformatf("rnd%0d_fwd1", c), fwd1, m_f1);
            check($sformatf("rnd%0d_hit2", c), 32'(hit2), 32'(m_h2));
            check($sformatf("rnd%0d_fwd2", c), fwd2, m_f2);
            check($sformatf("rnd%0d_count", c), 32'(count), 32'(mq.size()));
            check($sformatf("rnd%0d_count_bound", c), 32'(count <= DEPTH), 1);
            cyc();
            if (m_pop) void'(mq.pop_front());
            if (in_valid && m_rdy && in_a3 != 0) mq.push_back('{a3: in_a3, wd: in_wd, pc: in_pc});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
